control_sequencer: RTL and testbench

//  Hardwired Moore-style control unit for the DataPath. Runs fetch (T0-T2), decodes ir[31:27], then drives the
//  per-instruction T3-T7 control strobes: ld, ldi, st, add, sub, and, or, addi, halt.

---
 rtl/control_sequencer_pkg.sv | 92 +++++++++
 rtl/control_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// state encoding, instruction classes and the control-strobe bundle.
package control_sequencer_pkg;

  localparam int OPW  = 5;
  localparam int ALUW = 4;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUW-1:0] ALU_AND = 4'd2;
  localparam logic [ALUW-1:0] ALU_OR  = 4'd3;

  // T0..T7 encode as their step number so tstep is a direct copy.
  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_RST  = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CLS_LD,
    CLS_LDI,
    CLS_ST,
    CLS_ALU,
    CLS_ADDI,
    CLS_HALT,
    CLS_ILL
  } instr_class_t;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic mdr_out;
    logic r_out;
    logic ba_out;
    logic c_out;
    logic pc_in;
    logic mar_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic zlow_in;
    logic zhigh_in;
    logic r_in;
    logic inc_pc;
    logic read;
    logic write;
    logic gra;
    logic grb;
    logic grc;
  } ctrl_t;

  function automatic instr_class_t decode_op(input logic [OPW-1:0] op);
    case (op)
      OP_LD:                          return CLS_LD;
      OP_LDI:                         return CLS_LDI;
      OP_ST:                          return CLS_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  return CLS_ALU;
      OP_ADDI:                        return CLS_ADDI;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_ILL;
    endcase
  endfunction

  function automatic logic [ALUW-1:0] alu_sel(input logic [OPW-1:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the DataPath: fetch T0-T2, decode in T3,
// per-class execute steps T4-T7, with memory steps stretched on mem_done.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_done,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRout,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            PCin,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            Zhighin,
  output logic            Rin,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic [ALUW-1:0] alu_op,
  output logic            run,
  output logic            fault,
  output logic [3:0]      tstep
);

  state_t          state, state_nxt;
  logic [OPW-1:0]  op_q;
  logic            fault_q;
  instr_class_t    cls_ir, cls_q;
  ctrl_t           ctl;
  logic [ALUW-1:0] alu_nxt;
  logic            unused_ir;

  assign cls_ir    = decode_op(ir[31:27]);
  assign cls_q     = decode_op(op_q);
  assign unused_ir = ^ir[26:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= S_RST;
      op_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_T3) begin
        op_q <= ir[31:27];
        if (cls_ir == CLS_ILL) fault_q <= 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:  state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (mem_done) state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3:   state_nxt = (cls_ir == CLS_HALT || cls_ir == CLS_ILL) ? S_HALT : S_T4;
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = (cls_q == CLS_LD || cls_q == CLS_ST) ? S_T6 : S_T0;
      S_T6: begin
        if (cls_q == CLS_ST) state_nxt = S_T7;
        else if (mem_done)   state_nxt = S_T7;
      end
      S_T7: begin
        if (cls_q == CLS_LD) state_nxt = S_T0;
        else if (mem_done)   state_nxt = S_T0;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  // Only T3 looks at ir directly; later steps use the opcode captured at T3.
  always_comb begin
    ctl     = '0;
    alu_nxt = ALU_ADD;
    case (state)
      S_T0: begin
        ctl.pc_out  = 1'b1;
        ctl.mar_in  = 1'b1;
        ctl.inc_pc  = 1'b1;
        ctl.zlow_in = 1'b1;
      end
      S_T1: begin
        ctl.zlow_out = 1'b1;
        ctl.pc_in    = 1'b1;
        ctl.read     = 1'b1;
        ctl.mdr_in   = 1'b1;
      end
      S_T2: begin
        ctl.mdr_out = 1'b1;
        ctl.ir_in   = 1'b1;
      end
      S_T3: begin
        case (cls_ir)
          CLS_LD, CLS_LDI, CLS_ST: begin
            ctl.grb    = 1'b1;
            ctl.ba_out = 1'b1;
            ctl.y_in   = 1'b1;
          end
          CLS_ALU, CLS_ADDI: begin
            ctl.grb   = 1'b1;
            ctl.r_out = 1'b1;
            ctl.y_in  = 1'b1;
          end
          default: ctl = '0;
        endcase
      end
      S_T4: begin
        ctl.zlow_in  = 1'b1;
        ctl.zhigh_in = 1'b1;
        if (cls_q == CLS_ALU) begin
          ctl.grc = 1'b1;
          ctl.r_out = 1'b1;
          alu_nxt = alu_sel(op_q);
        end else begin
          ctl.c_out = 1'b1;
        end
      end
      S_T5: begin
        ctl.zlow_out = 1'b1;
        if (cls_q == CLS_LD || cls_q == CLS_ST) begin
          ctl.mar_in = 1'b1;
        end else begin
          ctl.gra  = 1'b1;
          ctl.r_in = 1'b1;
        end
      end
      S_T6: begin
        ctl.mdr_in = 1'b1;
        if (cls_q == CLS_ST) begin
          ctl.gra   = 1'b1;
          ctl.r_out = 1'b1;
        end else begin
          ctl.read = 1'b1;
        end
      end
      S_T7: begin
        if (cls_q == CLS_ST) begin
          ctl.write = 1'b1;
        end else begin
          ctl.mdr_out = 1'b1;
          ctl.gra     = 1'b1;
          ctl.r_in    = 1'b1;
        end
      end
      default: ctl = '0;
    endcase
  end

  assign run   = (state <= S_T7);
  assign tstep = run ? state : 4'hF;
  assign fault = fault_q;
  assign alu_op = alu_nxt;

  assign PCout    = ctl.pc_out;
  assign Zlowout  = ctl.zlow_out;
  assign Zhighout = ctl.zhigh_out;
  assign MDRout   = ctl.mdr_out;
  assign Rout     = ctl.r_out;
  assign BAout    = ctl.ba_out;
  assign Cout     = ctl.c_out;
  assign PCin     = ctl.pc_in;
  assign MARin    = ctl.mar_in;
  assign MDRin    = ctl.mdr_in;
  assign IRin     = ctl.ir_in;
  assign Yin      = ctl.y_in;
  assign Zlowin   = ctl.zlow_in;
  assign Zhighin  = ctl.zhigh_in;
  assign Rin      = ctl.r_in;
  assign IncPC    = ctl.inc_pc;
  assign Read     = ctl.read;
  assign Write    = ctl.write;
  assign Gra      = ctl.gra;
  assign Grb      = ctl.grb;
  assign Grc      = ctl.grc;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: each instruction is expanded from
// the instruction tables into a step plan and walked against the DUT outputs.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir = '0;
  logic        mem_done = 1'b0;
  logic PCout, Zlowout, Zhighout, MDRout, Rout, BAout, Cout;
  logic PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, Rin;
  logic IncPC, Read, Write, Gra, Grb, Grc;
  logic [3:0] alu_op;
  logic       run, fault;
  logic [3:0] tstep;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_done(mem_done),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Rin(Rin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .alu_op(alu_op), .run(run), .fault(fault), .tstep(tstep)
  );

  always #5 clock = ~clock;

  localparam logic [20:0] M_PCOUT   = 21'd1 << 20;
  localparam logic [20:0] M_ZLOWOUT = 21'd1 << 19;
  localparam logic [20:0] M_ZHIOUT  = 21'd1 << 18;
  localparam logic [20:0] M_MDROUT  = 21'd1 << 17;
  localparam logic [20:0] M_ROUT    = 21'd1 << 16;
  localparam logic [20:0] M_BAOUT   = 21'd1 << 15;
  localparam logic [20:0] M_COUT    = 21'd1 << 14;
  localparam logic [20:0] M_PCIN    = 21'd1 << 13;
  localparam logic [20:0] M_MARIN   = 21'd1 << 12;
  localparam logic [20:0] M_MDRIN   = 21'd1 << 11;
  localparam logic [20:0] M_IRIN    = 21'd1 << 10;
  localparam logic [20:0] M_YIN     = 21'd1 << 9;
  localparam logic [20:0] M_ZLOWIN  = 21'd1 << 8;
  localparam logic [20:0] M_ZHIIN   = 21'd1 << 7;
  localparam logic [20:0] M_RIN     = 21'd1 << 6;
  localparam logic [20:0] M_INCPC   = 21'd1 << 5;
  localparam logic [20:0] M_READ    = 21'd1 << 4;
  localparam logic [20:0] M_WRITE   = 21'd1 << 3;
  localparam logic [20:0] M_GRA     = 21'd1 << 2;
  localparam logic [20:0] M_GRB     = 21'd1 << 1;
  localparam logic [20:0] M_GRC     = 21'd1 << 0;

  logic [20:0] strobes;
  assign strobes = {PCout, Zlowout, Zhighout, MDRout, Rout, BAout, Cout,
                    PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, Rin,
                    IncPC, Read, Write, Gra, Grb, Grc};

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_fault = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Step plan for one instruction: step number, strobe mask, alu code, waits on mem_done.
  int          p_n;
  logic [3:0]  p_t [8];
  logic [20:0] p_m [8];
  logic [3:0]  p_a [8];
  bit          p_w [8];
  bit          p_halt, p_ill;

  task automatic add_step(input logic [3:0] t, input logic [20:0] m, input logic [3:0] a, input bit w);
    p_t[p_n] = t; p_m[p_n] = m; p_a[p_n] = a; p_w[p_n] = w;
    p_n++;
  endtask

  task automatic build_plan(input logic [4:0] op);
    logic [20:0] addr_t3, reg_t3, imm_t4, wb_t5;
    addr_t3 = M_GRB | M_BAOUT | M_YIN;
    reg_t3  = M_GRB | M_ROUT | M_YIN;
    imm_t4  = M_COUT | M_ZLOWIN | M_ZHIIN;
    wb_t5   = M_ZLOWOUT | M_GRA | M_RIN;
    p_n = 0; p_halt = 1'b0; p_ill = 1'b0;
    add_step(4'd0, M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 4'd0, 1'b0);
    add_step(4'd1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 4'd0, 1'b1);
    add_step(4'd2, M_MDROUT | M_IRIN, 4'd0, 1'b0);
    if (op == 5'b00000 || op == 5'b00010) begin
      add_step(4'd3, addr_t3, 4'd0, 1'b0);
      add_step(4'd4, imm_t4, 4'd0, 1'b0);
      add_step(4'd5, M_ZLOWOUT | M_MARIN, 4'd0, 1'b0);
      if (op == 5'b00000) begin
        add_step(4'd6, M_READ | M_MDRIN, 4'd0, 1'b1);
        add_step(4'd7, M_MDROUT | M_GRA | M_RIN, 4'd0, 1'b0);
      end else begin
        add_step(4'd6, M_GRA | M_ROUT | M_MDRIN, 4'd0, 1'b0);
        add_step(4'd7, M_WRITE, 4'd0, 1'b1);
      end
    end else if (op == 5'b00001) begin
      add_step(4'd3, addr_t3, 4'd0, 1'b0);
      add_step(4'd4, imm_t4, 4'd0, 1'b0);
      add_step(4'd5, wb_t5, 4'd0, 1'b0);
    end else if (op >= 5'b00011 && op <= 5'b00110) begin
      add_step(4'd3, reg_t3, 4'd0, 1'b0);
      // add/sub/and/or are consecutive opcodes mapping to ALU codes 0..3
      add_step(4'd4, M_GRC | M_ROUT | M_ZLOWIN | M_ZHIIN, 4'(op - 5'd3), 1'b0);
      add_step(4'd5, wb_t5, 4'd0, 1'b0);
    end else if (op == 5'b01100) begin
      add_step(4'd3, reg_t3, 4'd0, 1'b0);
      add_step(4'd4, imm_t4, 4'd0, 1'b0);
      add_step(4'd5, wb_t5, 4'd0, 1'b0);
    end else begin
      add_step(4'd3, 21'd0, 4'd0, 1'b0);
      p_halt = 1'b1;
      p_ill  = (op != 5'b11011);
    end
  endtask

  function automatic int lat_of(input logic [4:0] op);
    if (op == 5'b00000 || op == 5'b00010) return 8;
    if (op == 5'b00001 || op == 5'b01100 || (op >= 5'b00011 && op <= 5'b00110)) return 6;
    return 4;
  endfunction

  // Walk one instruction. w1/w2 are the wait cycles of the first/second wait
  // step (negative = random). clr_step >= 0 asserts clear on entry to that step.
  task automatic run_instr(input logic [4:0] op, input int w1, input int w2, input int clr_step);
    int nw, widx, waits, run_cycles;
    bit aborted;
    build_plan(op);
    ir = {op, 27'($urandom)};
    widx = 0; waits = 0; run_cycles = 0; aborted = 1'b0;
    for (int s = 0; s < p_n && !aborted; s++) begin
      nw = 0;
      if (p_w[s]) begin
        nw = (widx == 0) ? w1 : w2;
        if (nw < 0) nw = int'($urandom_range(0, 3));
        widx++;
      end
      waits += nw;
      for (int c = 0; c <= nw && !aborted; c++) begin
        @(negedge clock);
        check("tstep", 32'(tstep), 32'(p_t[s]));
        check("strobes", 32'(strobes), 32'(p_m[s]));
        check("alu_op", 32'(alu_op), 32'(p_a[s]));
        check("run", 32'(run), 32'd1);
        check("fault", 32'(fault), 32'(exp_fault));
        check("rd_wr_excl", 32'(Read & Write), 32'd0);
        if (run) run_cycles++;
        mem_done = p_w[s] ? (c == nw) : 1'($urandom_range(0, 1));
        if (clr_step >= 0 && int'(p_t[s]) == clr_step) begin
          clear = 1'b1;
          aborted = 1'b1;
        end
        @(posedge clock);
      end
    end
    if (p_ill) exp_fault = 1'b1;
    if (!aborted) check("latency", 32'(run_cycles), 32'(lat_of(op) + waits));
  endtask

  // One cycle in RST or HALT; clr_next is the clear level for the coming edge.
  task automatic idle_cycle(input bit clr_next);
    @(negedge clock);
    check("idle_tstep", 32'(tstep), 32'hF);
    check("idle_strobes", 32'(strobes), 32'd0);
    check("idle_alu_op", 32'(alu_op), 32'd0);
    check("idle_run", 32'(run), 32'd0);
    check("idle_fault", 32'(fault), 32'(exp_fault));
    mem_done = 1'($urandom_range(0, 1));
    clear = clr_next;
    @(posedge clock);
  endtask

  logic [4:0] legal_ops [8];
  logic [4:0] bad_ops [4];

  initial begin
    legal_ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                  5'b00100, 5'b00101, 5'b00110, 5'b01100};
    bad_ops   = '{5'b11111, 5'b00111, 5'b10000, 5'b01101};

    // clear held for two edges, then released
    clear = 1'b1;
    @(posedge clock);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    run_instr(5'b00000, 0, 0, -1);      // ld, no waits
    run_instr(5'b00000, 3, 2, -1);      // ld, T1 x4 and T6 x3 -> 13 cycles
    run_instr(5'b00010, 0, 2, -1);      // st, T7 held on mem_done
    run_instr(5'b00100, 0, 0, -1);      // sub

    for (int i = 0; i < 60; i++)
      run_instr(legal_ops[$urandom_range(0, 7)], -1, -1, -1);

    run_instr(5'b11011, -1, -1, -1);    // halt
    for (int i = 0; i < 9; i++) idle_cycle(1'b0);
    idle_cycle(1'b1);
    exp_fault = 1'b0;
    idle_cycle(1'b0);

    for (int k = 0; k < 2; k++) begin
      run_instr(bad_ops[$urandom_range(0, 3)], -1, -1, -1);
      for (int i = 0; i < 4; i++) idle_cycle(1'b0);
      idle_cycle(1'b1);
      exp_fault = 1'b0;
      idle_cycle(1'b0);
      run_instr(legal_ops[$urandom_range(0, 7)], -1, -1, -1);
    end

    // clear in the middle of a load's memory step
    run_instr(5'b00000, -1, 2, 6);
    idle_cycle(1'b0);
    run_instr(5'b00000, -1, -1, -1);
    run_instr(5'b00001, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
